mmio_bus_controller: RTL and testbench

Parametrised memory-mapped bus controller for the 8-bit CPU. It replaces the fixed-address combinational decoder with a registered, handshaked access engine. Each CPU access is decoded either to RAM or to one of `NUM_IO` I/O devices, each owning an `IO_REGS`-register window at the top of the address space. Strobes are held until the selected target acknowledges. A per-access timeout completes the transfer with an error if the target never answers.

---
 rtl/mmio_bus_controller.sv | 187 ++++++++++++++++++
 tb/tb_mmio_bus_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_controller.sv
// mmio_bus_controller: registered, handshaked access engine for the 8-bit CPU.
// A CPU request is latched in IDLE and decoded either to RAM or to one of
// NUM_IO device windows at the top of the address space. The chosen strobe is
// held through WAIT until the selected target acknowledges. If no acknowledge
// arrives within TIMEOUT strobe cycles, the access completes with an error.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no access outstanding; cpu_req is sampled here
//   ST_WAIT | strobe held on the latched target; waiting for ack/timeout
module mmio_bus_controller #(
  parameter int unsigned          ADDR_W  = 8,
  parameter int unsigned          DATA_W  = 8,
  parameter int unsigned          NUM_IO  = 2,
  parameter int unsigned          IO_REGS = 4,
  parameter logic [ADDR_W-1:0]    IO_BASE = 8'hF8,
  parameter int unsigned          TIMEOUT = 15,
  localparam int unsigned         RS_W    = (IO_REGS > 1) ? $clog2(IO_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_ready,
  output logic                     cpu_err,
  output logic                     busy,
  output logic                     mem_re,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ack,
  output logic [NUM_IO-1:0]        io_re,
  output logic [NUM_IO-1:0]        io_we,
  output logic [RS_W-1:0]          io_reg_sel,
  output logic [DATA_W-1:0]        io_wdata,
  input  logic [NUM_IO*DATA_W-1:0] io_rdata,
  input  logic [NUM_IO-1:0]        io_ack
);

  localparam int unsigned     RS_SH   = $clog2(IO_REGS);
  localparam int unsigned     DEV_W   = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam int unsigned     CNT_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned     IO_SPAN = NUM_IO * IO_REGS;
  // One extra bit so a window ending exactly at the top of the space compares cleanly.
  localparam logic [ADDR_W:0] IO_LO   = {1'b0, IO_BASE};
  localparam logic [ADDR_W:0] IO_HI   = IO_LO + IO_SPAN[ADDR_W:0];
  // The counter value seen in the last permitted strobe cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e             state_q,   state_d;
  logic               we_q,      we_d;
  logic               is_io_q,   is_io_d;
  logic [DEV_W-1:0]   dev_q,     dev_d;
  logic [RS_W-1:0]    reg_sel_q, reg_sel_d;
  logic [ADDR_W-1:0]  addr_q,    addr_d;
  logic [DATA_W-1:0]  wdata_q,   wdata_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [DATA_W-1:0]  rdata_q,   rdata_d;
  logic               ready_q,   ready_d;
  logic               err_q,     err_d;

  logic               req_in_io;
  logic [ADDR_W-1:0]  req_off;
  logic               sel_ack;
  logic [DATA_W-1:0]  sel_rdata;
  logic               in_wait;
  logic [NUM_IO-1:0]  dev_onehot;

  // Decode of the incoming CPU address (only used when the request is latched).
  always_comb begin
    req_in_io = ({1'b0, cpu_addr} >= IO_LO) && ({1'b0, cpu_addr} < IO_HI);
    req_off   = cpu_addr - IO_BASE;
  end

  // Acknowledge and read data of the latched target; other targets are ignored.
  always_comb begin
    sel_ack   = mem_ack;
    sel_rdata = mem_rdata;
    if (is_io_q) begin
      sel_ack   = io_ack[dev_q];
      sel_rdata = io_rdata[dev_q*DATA_W +: DATA_W];
    end
  end

  // Next-state logic: request capture, completion on ack, timeout handling.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    is_io_d   = is_io_q;
    dev_d     = dev_q;
    reg_sel_d = reg_sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          we_d      = cpu_we;
          addr_d    = cpu_addr;
          wdata_d   = cpu_wdata;
          is_io_d   = req_in_io;
          dev_d     = req_in_io ? DEV_W'(req_off >> RS_SH) : '0;
          reg_sel_d = req_in_io ? RS_W'(req_off & ADDR_W'(IO_REGS - 1)) : '0;
          cnt_d     = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sel_ack) begin
          // An ack in the final permitted cycle still counts as success.
          state_d = ST_IDLE;
          ready_d = 1'b1;
          if (!we_q) rdata_d = sel_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          err_d   = 1'b1;
          if (!we_q) rdata_d = '1;
        end else begin
          // Stops at CNT_LAST because the access terminates there; never wraps.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      is_io_q   <= 1'b0;
      dev_q     <= '0;
      reg_sel_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      is_io_q   <= is_io_d;
      dev_q     <= dev_d;
      reg_sel_q <= reg_sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  // Outputs are pure decodes of registers, so no input reaches an output combinationally.
  always_comb begin
    in_wait    = (state_q == ST_WAIT);
    dev_onehot = NUM_IO'(1) << dev_q;
    mem_re     = in_wait && !is_io_q && !we_q;
    mem_we     = in_wait && !is_io_q &&  we_q;
    io_re      = (in_wait && is_io_q && !we_q) ? dev_onehot : '0;
    io_we      = (in_wait && is_io_q &&  we_q) ? dev_onehot : '0;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    io_wdata   = wdata_q;
    io_reg_sel = reg_sel_q;
    cpu_rdata  = rdata_q;
    cpu_ready  = ready_q;
    cpu_err    = err_q;
    busy       = in_wait;
  end

endmodule

// File: tb/tb_mmio_bus_controller.sv
// Testbench for mmio_bus_controller: directed accesses from the test plan,
// then randomized accesses checked against a behavioural access model.
module tb_mmio_bus_controller;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready, cpu_err, busy;
  logic        mem_re, mem_we, mem_ack;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  io_re, io_we, io_ack, io_reg_sel;
  logic [7:0]  io_wdata;
  logic [15:0] io_rdata;

  logic        cpu_req_3, cpu_we_3;
  logic [7:0]  cpu_addr_3, cpu_wdata_3, cpu_rdata_3;
  logic        cpu_ready_3, cpu_err_3, busy_3;
  logic        mem_re_3, mem_we_3, mem_ack_3;
  logic [7:0]  mem_addr_3, mem_wdata_3, mem_rdata_3;
  logic [2:0]  io_re_3, io_we_3, io_ack_3;
  logic [0:0]  io_reg_sel_3;
  logic [7:0]  io_wdata_3;
  logic [23:0] io_rdata_3;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_rdata;

  always #5 clk = ~clk;

  mmio_bus_controller dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .cpu_err(cpu_err), .busy(busy),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .io_re(io_re), .io_we(io_we),
    .io_reg_sel(io_reg_sel), .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack)
  );

  mmio_bus_controller #(.NUM_IO(3), .IO_REGS(2), .IO_BASE(8'hF0)) dut3 (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req_3), .cpu_we(cpu_we_3),
    .cpu_addr(cpu_addr_3), .cpu_wdata(cpu_wdata_3), .cpu_rdata(cpu_rdata_3),
    .cpu_ready(cpu_ready_3), .cpu_err(cpu_err_3), .busy(busy_3),
    .mem_re(mem_re_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata_3), .mem_ack(mem_ack_3), .io_re(io_re_3), .io_we(io_we_3),
    .io_reg_sel(io_reg_sel_3), .io_wdata(io_wdata_3), .io_rdata(io_rdata_3), .io_ack(io_ack_3)
  );

  // Address map model: device index of an address, or -1 for RAM.
  function automatic int tgt_of(input int a, input int base, input int nio, input int nregs);
    if (a >= base && a < base + nio * nregs) return (a - base) / nregs;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_strobes_low(input string tag);
    chk({tag, " strobes"}, {28'd0, mem_re, mem_we, |io_re, |io_we}, 32'd0);
  endtask

  // One idle cycle after a completion: ready must already be gone.
  task automatic idle_check();
    step();
    chk("idle ready", 32'(cpu_ready), 32'd0);
    chk("idle busy", 32'(busy), 32'd0);
    chk_strobes_low("idle");
  endtask

  // Full access on the default instance. ack_at: strobe cycle carrying the ack (0 = never).
  // Leaves the bench at the cpu_ready cycle with cpu_req low.
  task automatic access(input bit we, input logic [7:0] addr, input logic [7:0] wd,
                        input int ack_at, input logic [7:0] rd, input bit noise);
    int         tgt, rg;
    logic       exp_err;
    logic [1:0] e_io, unsel;
    tgt  = tgt_of(int'(addr), 'hF8, 2, 4);
    rg   = (tgt >= 0) ? (int'(addr) - 'hF8) % 4 : 0;
    e_io = (tgt >= 0) ? 2'(1 << tgt) : 2'b00;
    unsel = ~e_io;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    step();
    for (int c = 1; c <= TO; c++) begin
      // Inputs wander during WAIT; only the latched copy may matter.
      cpu_req = 1'($urandom_range(0, 1));
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
      chk("wait busy", 32'(busy), 32'd1);
      chk("wait ready", 32'(cpu_ready), 32'd0);
      chk("mem_re", 32'(mem_re), 32'(tgt < 0 && !we));
      chk("mem_we", 32'(mem_we), 32'(tgt < 0 && we));
      chk("io_re", 32'(io_re), we ? 32'd0 : 32'(e_io));
      chk("io_we", 32'(io_we), we ? 32'(e_io) : 32'd0);
      if (tgt < 0) begin
        chk("mem_addr", 32'(mem_addr), 32'(addr));
        if (we) chk("mem_wdata", 32'(mem_wdata), 32'(wd));
      end else begin
        chk("io_reg_sel", 32'(io_reg_sel), 32'(rg));
        if (we) chk("io_wdata", 32'(io_wdata), 32'(wd));
      end
      chk("rdata hold", 32'(cpu_rdata), 32'(exp_rdata));
      mem_rdata = 8'($urandom);
      io_rdata  = 16'($urandom);
      if (noise) begin
        if (tgt < 0) io_ack = (c == 1) ? 2'b11 : 2'($urandom);
        else begin
          mem_ack = (c == 1) ? 1'b1 : 1'($urandom);
          io_ack  = ((c == 1) ? 2'b11 : 2'($urandom)) & unsel;
        end
      end
      if (c == ack_at) begin
        if (tgt < 0) begin mem_ack = 1'b1; mem_rdata = rd; end
        else begin io_ack = io_ack | e_io; io_rdata[tgt*8 +: 8] = rd; end
      end
      step();
      mem_ack = 1'b0; io_ack = 2'b00;
      if (c == ack_at) break;
    end
    cpu_req = 1'b0;
    exp_err = !(ack_at >= 1 && ack_at <= TO);
    if (!we) exp_rdata = exp_err ? 8'hFF : rd;
    chk("done ready", 32'(cpu_ready), 32'd1);
    chk("done err", 32'(cpu_err), 32'(exp_err));
    chk("done rdata", 32'(cpu_rdata), 32'(exp_rdata));
    chk("done busy", 32'(busy), 32'd0);
    chk_strobes_low("done");
  endtask

  // Single read on the 3-device instance, acked in the first strobe cycle.
  task automatic access3(input logic [7:0] addr, input logic [7:0] rd);
    int tgt, rg;
    tgt = tgt_of(int'(addr), 'hF0, 3, 2);
    rg  = (tgt >= 0) ? (int'(addr) - 'hF0) % 2 : 0;
    cpu_req_3 = 1'b1; cpu_we_3 = 1'b0; cpu_addr_3 = addr;
    step();
    cpu_req_3 = 1'b0;
    chk("d3 io_re", 32'(io_re_3), (tgt >= 0) ? 32'(1 << tgt) : 32'd0);
    chk("d3 mem_re", 32'(mem_re_3), 32'(tgt < 0));
    if (tgt >= 0) chk("d3 reg_sel", 32'(io_reg_sel_3), 32'(rg));
    else          chk("d3 mem_addr", 32'(mem_addr_3), 32'(addr));
    io_rdata_3 = 24'($urandom);
    if (tgt < 0) begin mem_ack_3 = 1'b1; mem_rdata_3 = rd; end
    else begin io_ack_3 = 3'(1 << tgt); io_rdata_3[tgt*8 +: 8] = rd; end
    step();
    mem_ack_3 = 1'b0; io_ack_3 = 3'b000;
    chk("d3 ready", 32'(cpu_ready_3), 32'd1);
    chk("d3 err", 32'(cpu_err_3), 32'd0);
    chk("d3 rdata", 32'(cpu_rdata_3), 32'(rd));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         ack_at, r;
    logic [7:0] a;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    mem_rdata = 8'h00; mem_ack = 1'b0; io_rdata = 16'h0; io_ack = 2'b00;
    cpu_req_3 = 1'b0; cpu_we_3 = 1'b0; cpu_addr_3 = 8'h00; cpu_wdata_3 = 8'h00;
    mem_rdata_3 = 8'h00; mem_ack_3 = 1'b0; io_rdata_3 = 24'h0; io_ack_3 = 3'b000;
    exp_rdata = 8'h00;
    step(); step();
    rst_n = 1'b1;
    chk("rst ready", 32'(cpu_ready), 32'd0);
    chk("rst err", 32'(cpu_err), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rdata", 32'(cpu_rdata), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk_strobes_low("rst");
    idle_check();

    // RAM read acked on the 3rd strobe cycle.
    access(1'b0, 8'h10, 8'h00, 3, 8'h5A, 1'b0);
    idle_check();
    // Device write with stray acks from the other device and RAM.
    access(1'b1, 8'hFE, 8'h3C, 2, 8'h00, 1'b1);
    idle_check();
    // Decode boundaries on the default map.
    access(1'b0, 8'hF7, 8'h00, 1, 8'h11, 1'b0);
    access(1'b0, 8'hF8, 8'h00, 1, 8'h22, 1'b0);
    access(1'b0, 8'hFB, 8'h00, 1, 8'h33, 1'b0);
    access(1'b0, 8'hFC, 8'h00, 1, 8'h44, 1'b0);
    access(1'b0, 8'hFF, 8'h00, 1, 8'h55, 1'b0);
    idle_check();
    // Timeout, then ack in the last permitted cycle; back-to-back into 0x20.
    access(1'b0, 8'hF9, 8'h00, 0, 8'h00, 1'b0);
    idle_check();
    access(1'b0, 8'hF9, 8'h00, TO, 8'h77, 1'b0);
    access(1'b0, 8'h20, 8'h00, 1, 8'h66, 1'b0);
    access(1'b1, 8'h21, 8'h99, 0, 8'h00, 1'b1);
    idle_check();

    // Decode on the 3-device, 2-register map based at 0xF0.
    access3(8'hEF, 8'h01);
    access3(8'hF0, 8'h02);
    access3(8'hF3, 8'h03);
    access3(8'hF5, 8'h04);
    access3(8'hF4, 8'h05);

    // Reset in the middle of a device read; the late ack must be ignored.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'hF9; cpu_wdata = 8'hA5;
    step();
    cpu_req = 1'b0;
    step(); step();
    chk("pre-rst io_re", 32'(io_re), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_rdata = 8'h00;
    chk("mid-rst busy", 32'(busy), 32'd0);
    chk("mid-rst ready", 32'(cpu_ready), 32'd0);
    chk("mid-rst err", 32'(cpu_err), 32'd0);
    chk("mid-rst rdata", 32'(cpu_rdata), 32'd0);
    chk("mid-rst mem_addr", 32'(mem_addr), 32'd0);
    chk("mid-rst reg_sel", 32'(io_reg_sel), 32'd0);
    chk("mid-rst wdata", 32'({mem_wdata, io_wdata}), 32'd0);
    chk_strobes_low("mid-rst");
    io_ack = 2'b01; io_rdata = 16'hBEEF;
    step();
    io_ack = 2'b00;
    chk("late ack ready", 32'(cpu_ready), 32'd0);
    chk("late ack busy", 32'(busy), 32'd0);
    idle_check();
    chk("late ack rdata", 32'(cpu_rdata), 32'd0);

    // Randomized accesses against the access model.
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 1) == 1) ? (8'hF0 | 8'($urandom_range(0, 15))) : 8'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      ack_at = 0;
      else if (r == 1) ack_at = TO;
      else             ack_at = $urandom_range(1, 6);
      access(1'($urandom_range(0, 1)), a, 8'($urandom), ack_at, 8'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_check();
    end
    idle_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
